// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = $clog2(NUM_REGS);
   localparam int WB_XLEN   = 32;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } arb_state_t;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [WB_XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small shift-style FIFO of writeback requests. Slot 0 is always the head.
// Per-slot rd/valid are exported so the arbiter can detect WAW hazards.
import regfile_arb_pkg::*;

module wb_fifo #(
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                               clk,
   input  logic                               rst_b,
   input  logic                               push_i,
   input  wb_req_t                            push_req_i,
   input  logic                               pop_i,
   output wb_req_t                            head_o,
   output logic                               full_o,
   output logic                               empty_o,
   output logic [CW-1:0]                      count_o,
   output logic [DEPTH-1:0][REG_IDX_W-1:0]    entry_rd_o,
   output logic [DEPTH-1:0]                   entry_valid_o
);

   wb_req_t [DEPTH-1:0] entriesQ;
   wb_req_t [DEPTH-1:0] entriesD;
   logic [CW-1:0]       countQ;
   logic [CW-1:0]       countD;
   logic [CW-1:0]       slot;
   logic                doPush;
   logic                doPop;

   assign doPop  = pop_i && (countQ != '0);
   assign doPush = push_i && ((countQ != CW'(DEPTH)) || doPop);

   // Shift the queue on pop, then drop a pushed request into the first free slot.
   always_comb begin
      entriesD = entriesQ;
      slot     = countQ;
      if (doPop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            entriesD[i] = entriesQ[i+1];
         end
         slot = countQ - CW'(1);
      end
      if (doPush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == slot) begin
               entriesD[i] = push_req_i;
            end
         end
      end
   end

   // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      countD = countQ;
      unique case ({doPush, doPop})
         2'b10:   countD = countQ + CW'(1);
         2'b01:   countD = countQ - CW'(1);
         default: countD = countQ;
      endcase
   end

   // Storage and occupancy registers; reset discards everything buffered.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         entriesQ <= '0;
         countQ   <= '0;
      end else begin
         entriesQ <= entriesD;
         countQ   <= countD;
      end
   end

   // Expose per-slot destination and occupancy for the hazard compare.
   always_comb begin
      entry_rd_o    = '0;
      entry_valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_rd_o[i]    = entriesQ[i].rd;
         entry_valid_o[i] = (CW'(i) < countQ);
      end
   end

   assign head_o  = entriesQ[0];
   assign empty_o = (countQ == '0);
   assign full_o  = (countQ == CW'(DEPTH));
   assign count_o = countQ;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// pipeline writeback (A) and buffered long-latency results (B), keeping
// same-register write order, bounding B starvation, and draining on halt.
import regfile_arb_pkg::*;

module regfile_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                             clk,
   input  logic                             rst_b,
   input  logic                             a_valid,
   output logic                             a_ready,
   input  logic [REG_IDX_W-1:0]             a_rd,
   input  logic [XLEN-1:0]                  a_data,
   input  logic                             b_valid,
   output logic                             b_ready,
   input  logic [REG_IDX_W-1:0]             b_rd,
   input  logic [XLEN-1:0]                  b_data,
   output logic                             rd_we,
   output logic [REG_IDX_W-1:0]             rd_num,
   output logic [XLEN-1:0]                  rd_data,
   input  logic                             halt_req,
   output logic                             halted,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  pend_cnt
);

   localparam int             CW         = $clog2(FIFO_DEPTH + 1);
   localparam int             SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t                            stateQ;
   arb_state_t                            stateD;
   logic [SW-1:0]                         starveQ;
   logic [SW-1:0]                         starveD;
   logic                                  rdWeQ;
   logic                                  rdWeD;
   logic [REG_IDX_W-1:0]                  rdNumQ;
   logic [REG_IDX_W-1:0]                  rdNumD;
   logic [XLEN-1:0]                       rdDataQ;
   logic [XLEN-1:0]                       rdDataD;

   logic                                  fifoPush;
   logic                                  fifoPop;
   logic                                  fifoFull;
   logic                                  fifoEmpty;
   logic [CW-1:0]                         fifoCount;
   wb_req_t                               headReq;
   wb_req_t                               pushReq;
   logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0]  entryRd;
   logic [FIFO_DEPTH-1:0]                 entryValid;

   logic                                  wawHit;
   logic                                  starved;
   logic                                  holdOffA;
   logic                                  grantA;

   assign pushReq = {b_rd, WB_XLEN'(b_data)};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .rst_b         (rst_b),
      .push_i        (fifoPush),
      .push_req_i    (pushReq),
      .pop_i         (fifoPop),
      .head_o        (headReq),
      .full_o        (fifoFull),
      .empty_o       (fifoEmpty),
      .count_o       (fifoCount),
      .entry_rd_o    (entryRd),
      .entry_valid_o (entryValid)
   );

   // An A write to a register that still has an older buffered B write must wait.
   always_comb begin
      wawHit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entryValid[i] && (entryRd[i] == a_rd)) begin
            wawHit = 1'b1;
         end
      end
      if (a_rd == '0) begin
         wawHit = 1'b0;
      end
   end

   assign starved  = (starveQ == STARVE_MAX);
   assign holdOffA = !fifoEmpty && (starved || wawHit);

   // Halt sequencing state register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stateQ <= RUN;
      end else begin
         stateQ <= stateD;
      end
   end

   // Halt sequencing: drain until the FIFO and the output stage are both idle.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         RUN:    if (halt_req) stateD = DRAIN;
         DRAIN:  if (fifoEmpty && !rdWeQ) stateD = HALTED;
         HALTED: stateD = HALTED;
         default: stateD = RUN;
      endcase
   end

   // Per-state handshakes, FIFO pop decision and the halted flag.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      fifoPop = 1'b0;
      halted  = 1'b0;
      unique case (stateQ)
         RUN: begin
            a_ready = !holdOffA;
            b_ready = !fifoFull;
            fifoPop = !fifoEmpty && (!a_valid || starved || wawHit);
         end
         DRAIN: begin
            fifoPop = !fifoEmpty;
            halted  = fifoEmpty && !rdWeQ;
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

   assign fifoPush = b_valid && b_ready;
   assign grantA   = a_valid && a_ready && !fifoPop;

   // Select the write for next cycle; x0 grants are consumed without a write.
   always_comb begin
      rdWeD   = 1'b0;
      rdNumD  = rdNumQ;
      rdDataD = rdDataQ;
      if (fifoPop) begin
         if (headReq.rd != '0) begin
            rdWeD   = 1'b1;
            rdNumD  = headReq.rd;
            rdDataD = XLEN'(headReq.data);
         end
      end else if (grantA) begin
         if (a_rd != '0) begin
            rdWeD   = 1'b1;
            rdNumD  = a_rd;
            rdDataD = a_data;
         end
      end
   end

   // Count A wins while B waits; any pop or an empty FIFO restarts the count.
   always_comb begin
      starveD = starveQ;
      if (fifoPop || fifoEmpty) begin
         starveD = '0;
      end else if (grantA && !starved) begin
         starveD = starveQ + SW'(1);
      end
   end

   // Registered write port and starvation counter.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rdWeQ   <= 1'b0;
         rdNumQ  <= '0;
         rdDataQ <= '0;
         starveQ <= '0;
      end else begin
         rdWeQ   <= rdWeD;
         rdNumQ  <= rdNumD;
         rdDataQ <= rdDataD;
         starveQ <= starveD;
      end
   end

   assign rd_we    = rdWeQ;
   assign rd_num   = rdNumQ;
   assign rd_data  = rdDataQ;
   assign pend_cnt = fifoCount;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        rd_we;
   logic [4:0]  rd_num;
   logic [31:0] rd_data;
   logic        halt_req;
   logic        halted;
   logic [1:0]  pend_cnt;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } expWrite_t;

   expWrite_t expQ[$];
   int        testsRun  = 0;
   int        failCount = 0;

   regfile_wb_arbiter #(
      .XLEN         (32),
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_rd     (a_rd),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_rd     (b_rd),
      .b_data   (b_data),
      .rd_we    (rd_we),
      .rd_num   (rd_num),
      .rd_data  (rd_data),
      .halt_req (halt_req),
      .halted   (halted),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bd);
      a_valid = av;
      a_rd    = ard;
      a_data  = ad;
      b_valid = bv;
      b_rd    = brd;
      b_data  = bd;
      #1;
   endtask

   task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
      expQ.push_back({rd, data});
   endtask

   // Every register-file write is matched in order against the scoreboard.
   always @(negedge clk) begin
      expWrite_t e;
      if (rst_b && rd_we) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_write", 32'(rd_we), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("wr_rd", 32'(rd_num), 32'(e.rd));
            checkOutput("wr_data", rd_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_b    = 1'b0;
      halt_req = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) tick();
      checkOutput("rst_rd_we", 32'(rd_we), 32'd0);
      checkOutput("rst_rd_num", 32'(rd_num), 32'd0);
      checkOutput("rst_rd_data", rd_data, 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_pend", 32'(pend_cnt), 32'd0);
      checkOutput("rst_a_ready", 32'(a_ready), 32'd1);
      checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
      rst_b = 1'b1;
      tick();

      // A only
      applyStimulus(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
      checkOutput("a_only_ready", 32'(a_ready), 32'd1);
      expectWrite(5'd5, 32'h11);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("a_only_we", 32'(rd_we), 32'd1);
      checkOutput("a_only_num", 32'(rd_num), 32'd5);
      checkOutput("a_only_data", rd_data, 32'h11);
      tick();
      checkOutput("a_only_we_drop", 32'(rd_we), 32'd0);
      checkOutput("a_only_hold_num", 32'(rd_num), 32'd5);

      // B only
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB);
      checkOutput("b_only_ready", 32'(b_ready), 32'd1);
      expectWrite(5'd7, 32'hAB);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("b_only_pend1", 32'(pend_cnt), 32'd1);
      checkOutput("b_only_no_bypass", 32'(rd_we), 32'd0);
      tick();
      checkOutput("b_only_we", 32'(rd_we), 32'd1);
      checkOutput("b_only_num", 32'(rd_num), 32'd7);
      checkOutput("b_only_data", rd_data, 32'hAB);
      checkOutput("b_only_pend0", 32'(pend_cnt), 32'd0);

      // Starvation: one B entry, A saturating with distinct rd
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hB3);
      checkOutput("starve_b_ready", 32'(b_ready), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         applyStimulus(1'b1, 5'(10 + k), 32'(32'hA0 + k), 1'b0, 5'd0, 32'h0);
         checkOutput("starve_a_grant", 32'(a_ready), 32'd1);
         expectWrite(5'(10 + k), 32'(32'hA0 + k));
      end
      tick();
      applyStimulus(1'b1, 5'd15, 32'hA5, 1'b0, 5'd0, 32'h0);
      checkOutput("starve_holdoff", 32'(a_ready), 32'd0);
      checkOutput("starve_pend", 32'(pend_cnt), 32'd1);
      expectWrite(5'd3, 32'hB3);
      tick();
      checkOutput("starve_resume", 32'(a_ready), 32'd1);
      checkOutput("starve_pend0", 32'(pend_cnt), 32'd0);
      expectWrite(5'd15, 32'hA5);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // WAW on x9
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB9);
      expectWrite(5'd9, 32'hB9);
      tick();
      applyStimulus(1'b1, 5'd9, 32'hA9, 1'b0, 5'd0, 32'h0);
      checkOutput("waw_block", 32'(a_ready), 32'd0);
      tick();
      checkOutput("waw_release", 32'(a_ready), 32'd1);
      checkOutput("waw_b_first", rd_data, 32'hB9);
      expectWrite(5'd9, 32'hA9);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("waw_final_num", 32'(rd_num), 32'd9);
      checkOutput("waw_final_data", rd_data, 32'hA9);

      // Full FIFO and x0 request
      tick();
      applyStimulus(1'b1, 5'd21, 32'hD0, 1'b1, 5'd20, 32'hC0);
      checkOutput("full_a_ready0", 32'(a_ready), 32'd1);
      expectWrite(5'd21, 32'hD0);
      tick();
      applyStimulus(1'b1, 5'd23, 32'hD1, 1'b1, 5'd22, 32'hC1);
      checkOutput("full_b_ready1", 32'(b_ready), 32'd1);
      checkOutput("full_a_ready1", 32'(a_ready), 32'd1);
      expectWrite(5'd23, 32'hD1);
      tick();
      applyStimulus(1'b1, 5'd0, 32'hEE, 1'b1, 5'd24, 32'hC2);
      checkOutput("full_count", 32'(pend_cnt), 32'd2);
      checkOutput("full_b_ready", 32'(b_ready), 32'd0);
      checkOutput("x0_ready", 32'(a_ready), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd25, 32'hE1, 1'b0, 5'd0, 32'h0);
      checkOutput("x0_no_write", 32'(rd_we), 32'd0);
      checkOutput("full_no_push", 32'(pend_cnt), 32'd2);
      checkOutput("full_a_ready3", 32'(a_ready), 32'd1);
      expectWrite(5'd25, 32'hE1);
      tick();
      applyStimulus(1'b1, 5'd26, 32'hE2, 1'b0, 5'd0, 32'h0);
      checkOutput("full_a_ready4", 32'(a_ready), 32'd1);
      expectWrite(5'd26, 32'hE2);
      tick();
      applyStimulus(1'b1, 5'd27, 32'hE3, 1'b0, 5'd0, 32'h0);
      checkOutput("full_starve_hold", 32'(a_ready), 32'd0);
      expectWrite(5'd20, 32'hC0);
      tick();
      checkOutput("full_resume", 32'(a_ready), 32'd1);
      checkOutput("full_pend1", 32'(pend_cnt), 32'd1);
      expectWrite(5'd27, 32'hE3);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("full_pend_last", 32'(pend_cnt), 32'd1);
      expectWrite(5'd22, 32'hC1);
      tick();
      checkOutput("full_pend_empty", 32'(pend_cnt), 32'd0);

      // Halt with two buffered entries
      tick();
      applyStimulus(1'b1, 5'd13, 32'hE4, 1'b1, 5'd12, 32'hF2);
      expectWrite(5'd13, 32'hE4);
      tick();
      applyStimulus(1'b1, 5'd15, 32'hE5, 1'b1, 5'd14, 32'hF4);
      expectWrite(5'd15, 32'hE5);
      tick();
      halt_req = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("halt_pend", 32'(pend_cnt), 32'd2);
      expectWrite(5'd12, 32'hF2);
      expectWrite(5'd14, 32'hF4);
      tick();
      halt_req = 1'b0;
      #1;
      checkOutput("drain_a_ready", 32'(a_ready), 32'd0);
      checkOutput("drain_b_ready", 32'(b_ready), 32'd0);
      checkOutput("drain_we1", 32'(rd_we), 32'd1);
      checkOutput("drain_num1", 32'(rd_num), 32'd12);
      checkOutput("drain_halted0", 32'(halted), 32'd0);
      tick();
      checkOutput("drain_we2", 32'(rd_we), 32'd1);
      checkOutput("drain_num2", 32'(rd_num), 32'd14);
      checkOutput("drain_halted1", 32'(halted), 32'd0);
      tick();
      checkOutput("halt_we_off", 32'(rd_we), 32'd0);
      checkOutput("halt_one_after", 32'(halted), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd18, 32'h18, 1'b1, 5'd19, 32'h19);
      checkOutput("halted_sticky", 32'(halted), 32'd1);
      checkOutput("halted_a_ready", 32'(a_ready), 32'd0);
      checkOutput("halted_b_ready", 32'(b_ready), 32'd0);
      tick();
      checkOutput("halted_no_write", 32'(rd_we), 32'd0);
      checkOutput("halted_no_push", 32'(pend_cnt), 32'd0);

      // Reset out of HALTED, then reset in the middle of a drain
      rst_b = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("rst_halted_clear", 32'(halted), 32'd0);
      checkOutput("rst_run_a_ready", 32'(a_ready), 32'd1);
      tick();
      rst_b = 1'b1;
      tick();
      applyStimulus(1'b1, 5'd16, 32'hA6, 1'b1, 5'd17, 32'hB7);
      expectWrite(5'd16, 32'hA6);
      tick();
      applyStimulus(1'b1, 5'd18, 32'hA8, 1'b1, 5'd19, 32'hB8);
      expectWrite(5'd18, 32'hA8);
      tick();
      halt_req = 1'b1;
      applyStimulus(1'b1, 5'd20, 32'hAA, 1'b0, 5'd0, 32'h0);
      checkOutput("hr_a_ready", 32'(a_ready), 32'd1);
      checkOutput("hr_pend2", 32'(pend_cnt), 32'd2);
      expectWrite(5'd20, 32'hAA);
      tick();
      halt_req = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("hr_in_drain", 32'(a_ready), 32'd0);
      #4;
      rst_b = 1'b0;
      #1;
      checkOutput("hr_pend_clear", 32'(pend_cnt), 32'd0);
      checkOutput("hr_halted", 32'(halted), 32'd0);
      checkOutput("hr_we", 32'(rd_we), 32'd0);
      checkOutput("hr_run_a", 32'(a_ready), 32'd1);
      checkOutput("hr_run_b", 32'(b_ready), 32'd1);
      tick();
      rst_b = 1'b1;
      tick();
      checkOutput("hr_no_late_write", 32'(rd_we), 32'd0);
      checkOutput("hr_still_empty", 32'(pend_cnt), 32'd0);
      tick();
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
